i2s_adc_receiver: RTL and testbench
===================================

// Module: i2s_adc_receiver
// PURPOSE
//  I2S clock master and receiver for the external stereo ADC codec; the capture-side counterpart of the DAC I2S path.
//  Generates the bit clock and the LR select, and samples serial ADC data.
//  Assembles 16-bit left/right words and hands each stereo pair downstream over a valid/ready handshake.
//  Single-entry holding buffer; counts dropped pairs.
// PARAMETERS
//  CLK_DIV      18  bit-clock half period = CLK_DIV+1 clk cycles (default: frame = 64*19 = 1216 clk, ~41.1 kHz at 50 MHz)
//  SAMPLE_WIDTH 16  bits per channel slot (slot length = SAMPLE_WIDTH bit clocks)
// PORTS
//  clk                 in   1   system clock (50 MHz)
//  reset               in   1   asynchronous, active-low reset
//  i2sBitClock         out  1   I2S BCLK to ADC
//  i2sLeftRightSelect  out  1   I2S LRCLK to ADC; 0 = left slot, 1 = right slot
//  i2sSoundData        in   1   I2S serial data from ADC, MSB first, launched by ADC on BCLK falling edge
//  left_sample         out  16  left word of held pair (two's complement)
//  right_sample        out  16  right word of held pair
//  sample_valid        out  1   held pair valid
//  sample_ready        in   1   consumer accepts pair when valid & ready at posedge clk
//  overrun_count       out  8   saturating count of dropped pairs
// BEHAVIOUR
//  Reset (reset=0, async): div_cnt=0, i2sBitClock=0, i2sLeftRightSelect=0, bit_idx=0, shift reg=0.
//   Also cleared: left_sample=0, right_sample=0, sample_valid=0, overrun_count=0, sync flops=0, primed=0.
//  Clock gen: div_cnt counts 0..CLK_DIV and wraps to 0; on the div_cnt==CLK_DIV cycle, i2sBitClock toggles.
//   Toggle 0->1 = RISE event; toggle 1->0 = FALL event (single-cycle internal strobes, same cycle as toggle).
//  LR gen: bit_idx counts FALL events 0..SAMPLE_WIDTH-1.
//   On a FALL with bit_idx==SAMPLE_WIDTH-1: i2sLeftRightSelect toggles and bit_idx->0.
//   LRCLK therefore changes only on BCLK falling edges.
//  Input sync: i2sSoundData passes through 2 flops (sd_s); RISE events use sd_s (2-clk latency, << half period).
//  Capture: on every RISE event, shift <= {shift[14:0], sd_s}.
//   I2S one-bit delay: the first RISE after an LRCLK toggle shifts in the LSB of the previous slot.
//   After that shift, the shift reg holds the complete word of the channel != current i2sLeftRightSelect.
//   That cycle is the word-complete strobe:
//    - completed left (LRCLK now 1)  -> left_pend <= word
//    - completed right (LRCLK now 0) -> pair complete, {left_pend, word} offered to holding buffer
//  Priming: the first completed pair after reset is discarded (primed<=1); no valid and no overrun for it.
//  Holding buffer (checked at the pair-complete cycle, primed=1):
//   - sample_valid=0, or sample_valid=1 & sample_ready=1: load pair, sample_valid<=1 next cycle.
//   - sample_valid=1 & sample_ready=0: drop new pair, keep held pair.
//     overrun_count <= overrun_count+1, saturating at 255.
//  Other cycles: valid & ready -> sample_valid<=0. Outputs hold stable while valid & !ready.
//  Latency: sample_valid rises 1 clk after the RISE that completes the right word.
//  Reset mid-frame: all state returns to reset values immediately; a partial word is lost.
//   Priming repeats after reset.
//  No combinational path from sample_ready to any output; all outputs registered.
// TESTING
//  1 Reset, run 3 frames: BCLK period 38 clk, 50% duty; LRCLK toggles every 16 BCLK, only on a FALL cycle.
//    Check frame = 1216 clk.
//  2 ADC model sends L=16'hA5C3, R=16'h5A3C per frame, MSB 1 bit after LRCLK edge; sample_ready=1.
//    First pair discarded; then pairs (A5C3,5A3C) at 1216-clk spacing; valid 1 clk after right-LSB RISE.
//  3 Counting pattern L=n, R=~n, ready=1: every pair matches, none missing or duplicated, overrun_count=0.
//  4 sample_ready=0 for 3 pair times after first valid: first pair held stable, overrun_count=2.
//    Saturation: hold ready=0 for 300 pairs -> overrun_count=255.
//  5 ready asserted on the exact pair-complete cycle: new pair loaded, no overrun, valid stays 1.
//  6 Assert reset mid-right-slot: outputs and counters to reset values asynchronously.
//    After release, first pair discarded again, second pair correct.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
// I2S clock master and stereo capture path for the external ADC: generates BCLK/LRCLK,
// deserialises left/right words and offers each pair through a one-entry holding buffer.
module i2s_adc_receiver #(
    parameter int CLK_DIV      = 18,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    i2sBitClock,
    output logic                    i2sLeftRightSelect,
    input  logic                    i2sSoundData,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic [7:0]              overrun_count
);
    localparam int DIV_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int IDX_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_WIDTH - 1);

    logic [DIV_W-1:0]        div_cnt_r, div_cnt_s;
    logic                    bclk_r, bclk_s;
    logic                    lrclk_r, lrclk_s;
    logic [IDX_W-1:0]        bit_idx_r, bit_idx_s;
    logic                    sd_meta_r, sd_sync_r;
    logic [SAMPLE_WIDTH-1:0] shift_r, shift_s, shift_next_s;
    logic [SAMPLE_WIDTH-1:0] left_pend_r, left_pend_s;
    logic                    first_rise_r, first_rise_s;
    logic                    primed_r, primed_s;
    logic [SAMPLE_WIDTH-1:0] left_r, left_s, right_r, right_s;
    logic                    valid_r, valid_s;
    logic [7:0]              ovf_r, ovf_s;
    logic                    tick_s, rise_s, fall_s, slot_end_s;
    logic                    word_done_s, left_done_s, pair_done_s;

    // Bit-clock edge strobes and word-complete detection
    always_comb begin
        tick_s       = (div_cnt_r == DIV_LAST);
        rise_s       = tick_s & ~bclk_r;
        fall_s       = tick_s & bclk_r;
        slot_end_s   = fall_s & (bit_idx_r == IDX_LAST);
        shift_next_s = {shift_r[SAMPLE_WIDTH-2:0], sd_sync_r};
        // One-bit I2S delay: the first RISE of a slot carries the previous slot's LSB
        word_done_s  = rise_s & first_rise_r;
        left_done_s  = word_done_s & lrclk_r;
        pair_done_s  = word_done_s & ~lrclk_r;
    end

    // Next-state for clock generation, capture and holding buffer
    always_comb begin
        div_cnt_s    = tick_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
        bclk_s       = tick_s ? ~bclk_r : bclk_r;
        lrclk_s      = slot_end_s ? ~lrclk_r : lrclk_r;
        shift_s      = rise_s ? shift_next_s : shift_r;
        left_pend_s  = left_done_s ? shift_next_s : left_pend_r;
        bit_idx_s    = bit_idx_r;
        first_rise_s = first_rise_r;
        primed_s     = primed_r;
        left_s       = left_r;
        right_s      = right_r;
        valid_s      = valid_r;
        ovf_s        = ovf_r;
        if (fall_s) begin
            bit_idx_s = (bit_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : bit_idx_r + IDX_W'(1);
        end else begin
            bit_idx_s = bit_idx_r;
        end
        if (slot_end_s) begin
            first_rise_s = 1'b1;
        end else if (rise_s) begin
            first_rise_s = 1'b0;
        end else begin
            first_rise_s = first_rise_r;
        end
        if (pair_done_s) begin
            if (!primed_r) begin
                primed_s = 1'b1;
            end else if (!valid_r || sample_ready) begin
                left_s  = left_pend_r;
                right_s = shift_next_s;
                valid_s = 1'b1;
            end else if (ovf_r != 8'hFF) begin
                ovf_s = ovf_r + 8'd1;
            end else begin
                ovf_s = ovf_r;
            end
        end else if (valid_r && sample_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            bclk_r       <= 1'b0;
            lrclk_r      <= 1'b0;
            bit_idx_r    <= {IDX_W{1'b0}};
            sd_meta_r    <= 1'b0;
            sd_sync_r    <= 1'b0;
            shift_r      <= {SAMPLE_WIDTH{1'b0}};
            left_pend_r  <= {SAMPLE_WIDTH{1'b0}};
            first_rise_r <= 1'b0;
            primed_r     <= 1'b0;
            left_r       <= {SAMPLE_WIDTH{1'b0}};
            right_r      <= {SAMPLE_WIDTH{1'b0}};
            valid_r      <= 1'b0;
            ovf_r        <= 8'd0;
        end else begin
            div_cnt_r    <= div_cnt_s;
            bclk_r       <= bclk_s;
            lrclk_r      <= lrclk_s;
            bit_idx_r    <= bit_idx_s;
            sd_meta_r    <= i2sSoundData;
            sd_sync_r    <= sd_meta_r;
            shift_r      <= shift_s;
            left_pend_r  <= left_pend_s;
            first_rise_r <= first_rise_s;
            primed_r     <= primed_s;
            left_r       <= left_s;
            right_r      <= right_s;
            valid_r      <= valid_s;
            ovf_r        <= ovf_s;
        end
    end

    assign i2sBitClock        = bclk_r;
    assign i2sLeftRightSelect = lrclk_r;
    assign left_sample        = left_r;
    assign right_sample       = right_r;
    assign sample_valid       = valid_r;
    assign overrun_count      = ovf_r;
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Self-checking bench for i2s_adc_receiver: acts as the ADC, predicts clock timing and
// the delivered pair stream from cycle arithmetic and a transaction-level buffer model.
module tb_i2s_adc_receiver;
    localparam int DIV   = 2;
    localparam int HP    = DIV + 1;
    localparam int FRAME = 64 * HP;
    localparam int NF    = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i2sBitClock, i2sLeftRightSelect;
    logic        i2sSoundData = 1'b0;
    logic [15:0] left_sample, right_sample;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic [7:0]  overrun_count;

    int checks = 0;
    int failures = 0;
    int c = 0;
    int mode = 0;
    logic ready_q = 1'b1;
    logic [15:0] lw [NF];
    logic [15:0] rw [NF];
    logic        m_primed = 1'b0, m_valid = 1'b0;
    logic [15:0] m_l = 16'd0, m_r = 16'd0;
    int          m_ovf = 0;
    logic        prev_bclk = 1'b0, prev_lr = 1'b0;
    int          bclk_rise_c = -1, lr_rise_c = -1, first_valid_c = -1;

    i2s_adc_receiver #(.CLK_DIV(DIV), .SAMPLE_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .i2sBitClock(i2sBitClock), .i2sLeftRightSelect(i2sLeftRightSelect),
        .i2sSoundData(i2sSoundData),
        .left_sample(left_sample), .right_sample(right_sample),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, c);
        end
    endtask

    // Cycle (counted from reset release) of the edge that completes frame f's right word
    function automatic int pc_cycle(input int f);
        return (64 * f + 65) * HP;
    endfunction

    function automatic int pc_frame(input int cc);
        int t;
        if (cc % HP != 0) return -1;
        t = cc / HP;
        if (t < 65 || (t - 65) % 64 != 0) return -1;
        return (t - 65) / 64;
    endfunction

    task automatic gen_frame(input int f);
        if (f < NF) begin
            case (mode)
                0: begin lw[f] = 16'hA5C3; rw[f] = 16'h5A3C; end
                1: begin lw[f] = 16'(f); rw[f] = ~16'(f); end
                default: begin lw[f] = 16'($urandom); rw[f] = 16'($urandom); end
            endcase
        end
    endtask

    task automatic set_ready(input logic r);
        ready_q = r;
        sample_ready = r;
    endtask

    task automatic step();
        int f, m, j, b;
        logic [15:0] w;
        @(posedge clk);
        c++;
        #1;
        f = pc_frame(c);
        if (f >= 0) begin
            if (!m_primed) m_primed = 1'b1;
            else if (!m_valid || ready_q) begin
                m_valid = 1'b1; m_l = lw[f]; m_r = rw[f];
            end else if (m_ovf < 255) m_ovf++;
        end else if (m_valid && ready_q) m_valid = 1'b0;
        check_val("valid", 32'(sample_valid), 32'(m_valid));
        if (m_valid) begin
            check_val("left", 32'(left_sample), 32'(m_l));
            check_val("right", 32'(right_sample), 32'(m_r));
        end
        check_val("overrun", 32'(overrun_count), 32'(m_ovf));
        check_val("bclk", 32'(i2sBitClock), 32'((c / HP) % 2));
        check_val("lrclk", 32'(i2sLeftRightSelect), 32'((c / (32 * HP)) % 2));
        if (sample_valid && first_valid_c < 0) first_valid_c = c;
        if (i2sBitClock && !prev_bclk) begin
            if (bclk_rise_c >= 0) check_val("bclk_period", 32'(c - bclk_rise_c), 32'(2 * HP));
            bclk_rise_c = c;
        end
        if (i2sLeftRightSelect && !prev_lr) begin
            if (lr_rise_c >= 0) check_val("frame_len", 32'(c - lr_rise_c), 32'(FRAME));
            lr_rise_c = c;
        end
        prev_bclk = i2sBitClock;
        prev_lr = i2sLeftRightSelect;
        // ADC launches bit b of slot j just after BCLK fall number 16*j+b
        if (c % (2 * HP) == 0) begin
            m = c / (2 * HP);
            j = (m - 1) / 16;
            b = m - 16 * j;
            f = j / 2;
            if (j % 2 == 0 && b == 1) gen_frame(f);
            if (f < NF) begin
                w = (j % 2 == 0) ? lw[f] : rw[f];
                i2sSoundData = w[16 - b];
            end else begin
                i2sSoundData = 1'b0;
            end
        end
    endtask

    task automatic run_until(input int target);
        while (c < target) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_bclk"}, 32'(i2sBitClock), 32'd0);
        check_val({tag, "_lrclk"}, 32'(i2sLeftRightSelect), 32'd0);
        check_val({tag, "_valid"}, 32'(sample_valid), 32'd0);
        check_val({tag, "_left"}, 32'(left_sample), 32'd0);
        check_val({tag, "_right"}, 32'(right_sample), 32'd0);
        check_val({tag, "_overrun"}, 32'(overrun_count), 32'd0);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        c = 0;
        m_primed = 1'b0; m_valid = 1'b0; m_ovf = 0;
        prev_bclk = 1'b0; prev_lr = 1'b0;
        bclk_rise_c = -1; lr_rise_c = -1; first_valid_c = -1;
        i2sSoundData = 1'b0;
    endtask

    initial begin
        int f0, t;
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        release_reset();

        // Fixed pattern: first pair discarded, pairs then arrive every frame
        mode = 0;
        run_until(FRAME * 5);
        check_val("first_valid_cycle", 32'(first_valid_c), 32'(pc_cycle(1)));

        // Counting pattern with a always-ready consumer
        mode = 1;
        run_until(FRAME * 13);
        check_val("count_overrun", 32'(overrun_count), 32'd0);

        // Back-pressure: hold first pair, drop two, then ready exactly on pair-complete
        mode = 2;
        f0 = 14;
        run_until(pc_cycle(f0));
        set_ready(1'b0);
        run_until(pc_cycle(f0 + 3) - 1);
        check_val("held_left", 32'(left_sample), 32'(lw[f0]));
        set_ready(1'b1);
        step();
        set_ready(1'b0);
        check_val("exact_valid", 32'(sample_valid), 32'd1);
        check_val("exact_left", 32'(left_sample), 32'(lw[f0 + 3]));
        check_val("exact_overrun", 32'(overrun_count), 32'd2);

        // Saturation after 300 dropped pairs
        run_until(pc_cycle(f0 + 303) + 2);
        check_val("sat_overrun", 32'(overrun_count), 32'd255);
        check_val("sat_right", 32'(right_sample), 32'(rw[f0 + 3]));

        // Reset in the middle of a right slot while a pair is held
        t = (c / FRAME + 1) * FRAME + 48 * HP + 1;
        run_until(t);
        check_val("pre_reset_valid", 32'(sample_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("held");
        set_ready(1'b1);
        release_reset();
        run_until(pc_cycle(3) + 2);
        check_val("post_reset_first_valid", 32'(first_valid_c), 32'(pc_cycle(1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
